// File: rtl/mem_access_sequencer_pkg.sv
// mem_access_sequencer_pkg: shared word type, read-type codes, op/state enums and auto-index defaults
package mem_access_sequencer_pkg;
    typedef logic [11:0] word;
    localparam logic DATA_READ = 1'b0;
    localparam logic INSTRUCTION_FETCH = 1'b1;
    localparam word DEF_AUTOINC_LO = 12'o0010;
    localparam word DEF_AUTOINC_HI = 12'o0017;
    typedef enum logic [1:0] {OP_FETCH, OP_READ, OP_WRITE, OP_ISZ} mem_op_t;
    typedef enum logic [2:0] {S_IDLE, S_PTR_RD, S_PTR_WB, S_OP_RD, S_OP_WR, S_ISZ_WR, S_DONE} seq_state_t;
endpackage

// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if: CPU request/response and memory_controller bus; master = requester/memory, slave = sequencer
interface mem_access_sequencer_if;
    import mem_access_sequencer_pkg::*;
    logic    req_valid;
    logic    req_ready;
    mem_op_t req_op;
    word     req_addr;
    logic    req_indirect;
    word     req_wdata;
    logic    rsp_valid;
    word     rsp_data;
    word     rsp_eaddr;
    logic    rsp_skip;
    word     mem_address;
    word     mem_write_data;
    logic    mem_read_enable;
    logic    mem_read_type;
    logic    mem_write_enable;
    word     mem_read_data;
    modport master (
        output req_valid, req_op, req_addr, req_indirect, req_wdata, mem_read_data,
        input  req_ready, rsp_valid, rsp_data, rsp_eaddr, rsp_skip,
               mem_address, mem_write_data, mem_read_enable, mem_read_type, mem_write_enable
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_indirect, req_wdata, mem_read_data,
        output req_ready, rsp_valid, rsp_data, rsp_eaddr, rsp_skip,
               mem_address, mem_write_data, mem_read_enable, mem_read_type, mem_write_enable
    );
endinterface

// File: rtl/mem_access_sequencer_timer.sv
// mem_access_timer: one strobe cycle then MEM_LAT held wait cycles; done and read capture on the last wait cycle
module mem_access_timer
    import mem_access_sequencer_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_write,
    input  logic read_type,
    input  word  addr,
    input  word  wdata,
    input  word  mem_read_data,
    output word  mem_address,
    output word  mem_write_data,
    output logic mem_read_enable,
    output logic mem_write_enable,
    output logic mem_read_type,
    output logic done,
    output word  rdata
);
    localparam int CW = $clog2(MEM_LAT + 2);
    logic [CW-1:0] cnt_q, cnt_d;
    word addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic re_q, re_d, we_q, we_d, type_q, type_d;
    always_comb begin
        done = cnt_q == CW'(1);
        cnt_d = start ? CW'(MEM_LAT + 1) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
        addr_d = start ? addr : addr_q;
        wdata_d = start ? wdata : wdata_q;
        type_d = start ? (is_write ? DATA_READ : read_type) : type_q;
        re_d = start && !is_write;
        we_d = start && is_write;
        rdata_d = done ? mem_read_data : rdata_q;
        rdata = rdata_d;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            type_q <= 1'b0;
            re_q <= 1'b0;
            we_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            type_q <= type_d;
            re_q <= re_d;
            we_q <= we_d;
            rdata_q <= rdata_d;
        end
    end
    assign mem_address = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_read_enable = re_q;
    assign mem_write_enable = we_q;
    assign mem_read_type = type_q;
endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: resolves indirect/auto-index addressing and sequences fetch/read/write/ISZ accesses
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int  MEM_LAT    = 1,
    parameter word AUTOINC_LO = DEF_AUTOINC_LO,
    parameter word AUTOINC_HI = DEF_AUTOINC_HI
) (
    input logic clk,
    input logic reset,
    mem_access_sequencer_if.slave bus
);
    seq_state_t state_q, state_d, op_st;
    mem_op_t op_q, op_d;
    word addr_q, addr_d, wdata_q, wdata_d, ptr_q, ptr_d, data_q, data_d;
    word rsp_data_q, rsp_data_d, rsp_eaddr_q, rsp_eaddr_d;
    logic ind_q, ind_d, first_q, first_d, rsp_skip_q, rsp_skip_d;
    logic accept, autoinc, fin, start, t_write, t_type, done;
    word eaddr_d, t_addr, t_wdata, rdata;
    always_comb begin
        accept = state_q == S_IDLE && bus.req_valid;
        autoinc = addr_q >= AUTOINC_LO && addr_q <= AUTOINC_HI;
        op_st = op_q == OP_WRITE ? S_OP_WR : S_OP_RD;
        state_d = state_q;
        op_d = op_q;
        addr_d = addr_q;
        ind_d = ind_q;
        wdata_d = wdata_q;
        ptr_d = ptr_q;
        data_d = data_q;
        first_d = accept;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d = bus.req_op;
                addr_d = bus.req_addr;
                ind_d = bus.req_indirect && bus.req_op != OP_FETCH;
                wdata_d = bus.req_wdata;
                state_d = ind_d ? S_PTR_RD : (bus.req_op == OP_WRITE ? S_OP_WR : S_OP_RD);
            end
            S_PTR_RD: if (done) begin
                ptr_d = rdata + word'(autoinc);
                state_d = autoinc ? S_PTR_WB : op_st;
            end
            S_PTR_WB: if (done) state_d = op_st;
            S_OP_RD: if (done) begin
                data_d = op_q == OP_ISZ ? rdata + 12'd1 : rdata;
                state_d = op_q == OP_ISZ ? S_ISZ_WR : S_DONE;
            end
            S_OP_WR: if (done) begin
                data_d = wdata_q;
                state_d = S_DONE;
            end
            S_ISZ_WR: if (done) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        // next access is launched in the same cycle the previous one completes, so strobes run back to back
        eaddr_d = ind_q ? ptr_d : addr_q;
        start = (first_q || (done && state_d != state_q)) && state_d != S_IDLE && state_d != S_DONE;
        t_write = state_d inside {S_PTR_WB, S_OP_WR, S_ISZ_WR};
        t_type = state_d == S_OP_RD && op_q == OP_FETCH ? INSTRUCTION_FETCH : DATA_READ;
        t_addr = state_d inside {S_PTR_RD, S_PTR_WB} ? addr_q : eaddr_d;
        t_wdata = state_d == S_PTR_WB ? ptr_d : (state_d == S_ISZ_WR ? data_d : wdata_q);
        fin = state_d == S_DONE && state_q != S_DONE;
        rsp_data_d = fin ? data_d : rsp_data_q;
        rsp_eaddr_d = fin ? eaddr_d : rsp_eaddr_q;
        rsp_skip_d = fin ? op_q == OP_ISZ && data_d == '0 : rsp_skip_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q <= OP_FETCH;
            addr_q <= '0;
            ind_q <= 1'b0;
            wdata_q <= '0;
            ptr_q <= '0;
            data_q <= '0;
            first_q <= 1'b0;
            rsp_data_q <= '0;
            rsp_eaddr_q <= '0;
            rsp_skip_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            addr_q <= addr_d;
            ind_q <= ind_d;
            wdata_q <= wdata_d;
            ptr_q <= ptr_d;
            data_q <= data_d;
            first_q <= first_d;
            rsp_data_q <= rsp_data_d;
            rsp_eaddr_q <= rsp_eaddr_d;
            rsp_skip_q <= rsp_skip_d;
        end
    end
    mem_access_timer #(.MEM_LAT(MEM_LAT)) u_timer (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .is_write         (t_write),
        .read_type        (t_type),
        .addr             (t_addr),
        .wdata            (t_wdata),
        .mem_read_data    (bus.mem_read_data),
        .mem_address      (bus.mem_address),
        .mem_write_data   (bus.mem_write_data),
        .mem_read_enable  (bus.mem_read_enable),
        .mem_write_enable (bus.mem_write_enable),
        .mem_read_type    (bus.mem_read_type),
        .done             (done),
        .rdata            (rdata)
    );
    assign bus.req_ready = state_q == S_IDLE;
    assign bus.rsp_valid = state_q == S_DONE;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_eaddr = rsp_eaddr_q;
    assign bus.rsp_skip = rsp_skip_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: random and directed requests against a word-level memory/addressing reference model
module tb_mem_access_sequencer;
    import mem_access_sequencer_pkg::*;
    localparam int MEM_LAT = 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    mem_access_sequencer_if bus();
    mem_access_sequencer #(.MEM_LAT(MEM_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    word mem [4096];
    word rm [4096];
    word rd_q = '0;
    int checks = 0, errors = 0;
    int n_re = 0, n_we = 0, n_both = 0, n_if = 0, n_rsp = 0;
    assign bus.mem_read_data = rd_q;
    always @(posedge clk) begin
        if (bus.mem_read_enable) rd_q <= mem[bus.mem_address];
        if (bus.mem_write_enable) mem[bus.mem_address] = bus.mem_write_data;
        if (bus.mem_read_enable) n_re++;
        if (bus.mem_write_enable) n_we++;
        if (bus.mem_read_enable && bus.mem_write_enable) n_both++;
        if (bus.mem_read_enable && bus.mem_read_type == INSTRUCTION_FETCH) n_if++;
        if (bus.rsp_valid) n_rsp++;
    end
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask
    task automatic setm(input int a, input int v);
        mem[a] = word'(v);
        rm[a] = word'(v);
    endtask
    task automatic do_op(input logic [1:0] op, input word a, input logic ind, input word wd);
        word ea, d, ptr;
        logic skip;
        int n, lat, re0, we0, if0, rsp0;
        n = 0;
        ea = a;
        skip = 1'b0;
        if (ind && op != OP_FETCH) begin
            ptr = rm[a];
            n = 1;
            if (a >= 12'o0010 && a <= 12'o0017) begin
                ptr = ptr + 12'd1;
                rm[a] = ptr;
                n = 2;
            end
            ea = ptr;
        end
        if (op == OP_WRITE) begin
            rm[ea] = wd;
            d = wd;
            n += 1;
        end else if (op == OP_ISZ) begin
            d = rm[ea] + 12'd1;
            rm[ea] = d;
            skip = d == '0;
            n += 2;
        end else begin
            d = rm[ea];
            n += 1;
        end
        re0 = n_re;
        we0 = n_we;
        if0 = n_if;
        rsp0 = n_rsp;
        @(negedge clk);
        chk("ready_before", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op = mem_op_t'(op);
        bus.req_addr = a;
        bus.req_indirect = ind;
        bus.req_wdata = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!bus.rsp_valid && lat < 40);
        chk("latency", lat, 1 + n * (1 + MEM_LAT));
        chk("rsp_data", bus.rsp_data, d);
        chk("rsp_eaddr", bus.rsp_eaddr, ea);
        chk("rsp_skip", bus.rsp_skip, skip);
        chk("strobes", (n_re - re0) + (n_we - we0), n);
        chk("fetch_strobes", n_if - if0, op == OP_FETCH);
        chk("mem_eaddr", mem[ea], rm[ea]);
        chk("mem_reqaddr", mem[a], rm[a]);
        @(posedge clk);
        #1;
        chk("rsp_pulse", bus.rsp_valid, 0);
        chk("rsp_count", n_rsp - rsp0, 1);
        chk("ready_after", bus.req_ready, 1);
    endtask
    initial begin
        int we0, rsp0;
        bus.req_valid = 1'b0;
        bus.req_op = OP_FETCH;
        bus.req_addr = '0;
        bus.req_indirect = 1'b0;
        bus.req_wdata = '0;
        for (int i = 0; i < 4096; i++) setm(i, $urandom_range(0, 4095));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_re", bus.mem_read_enable, 0);
        chk("rst_we", bus.mem_write_enable, 0);
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_skip", bus.rsp_skip, 0);
        @(negedge clk) reset = 1'b0;
        setm(12'o0200, 12'o1234);
        do_op(OP_READ, 12'o0200, 1'b0, '0);
        do_op(OP_FETCH, 12'o0200, 1'b1, '0);
        setm(12'o0300, 12'o4000);
        setm(12'o4000, 12'o0055);
        do_op(OP_READ, 12'o0300, 1'b1, '0);
        setm(12'o0010, 12'o7777);
        do_op(OP_WRITE, 12'o0010, 1'b1, 12'o1111);
        chk("autoinc_ptr", mem[12'o0010], 12'o0000);
        chk("autoinc_data", mem[12'o0000], 12'o1111);
        setm(12'o0400, 12'o7777);
        do_op(OP_ISZ, 12'o0400, 1'b0, '0);
        setm(12'o0400, 12'o0005);
        do_op(OP_ISZ, 12'o0400, 1'b0, '0);
        do_op(OP_READ, 12'o0007, 1'b1, '0);
        do_op(OP_READ, 12'o0020, 1'b1, '0);
        do_op(OP_ISZ, 12'o0017, 1'b1, '0);
        setm(12'o0400, 12'o0005);
        we0 = n_we;
        rsp0 = n_rsp;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = OP_ISZ;
        bus.req_addr = 12'o0400;
        bus.req_indirect = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", bus.req_ready, 1);
        chk("mid_rst_rsp", bus.rsp_valid, 0);
        chk("mid_rst_we", bus.mem_write_enable, 0);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_writes", n_we - we0, 0);
        chk("mid_rst_rsps", n_rsp - rsp0, 0);
        chk("mid_rst_mem", mem[12'o0400], 12'o0005);
        for (int k = 0; k < 200; k++)
            do_op(2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0 ? word'($urandom_range(8, 15)) : word'($urandom_range(0, 4095)),
                  1'($urandom_range(0, 1)), word'($urandom_range(0, 4095)));
        chk("both_enables", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
